// File: rtl/disp_source_sched.sv
// disp_source_sched: round-robin scheduler that time-shares the two-digit hex
// display between NUM_SRC 8-bit sources. Each valid source is shown for DWELL
// cycles. hold freezes the dwell count, and step forces a manual advance.
module disp_source_sched #(
  parameter int NUM_SRC = 4,
  parameter int DWELL   = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*8-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic                       hold,
  input  logic                       step,
  output logic [7:0]                 data_out,
  output logic [$clog2(NUM_SRC)-1:0] sel,
  output logic                       blank,
  output logic                       switched
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int VW = 1 << SW;           // index space padded to a power of two
  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SHOW, ADVANCE} state_t;

  state_t         state_reg, state_next;
  logic [SW-1:0]  sel_reg, sel_next;
  logic [7:0]     data_out_reg, data_out_next;
  logic           blank_reg, blank_next;
  logic           switched_reg, switched_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           step_q_reg;

  logic [7:0]     src_bytes [VW];
  logic [VW-1:0]  valid_ext;
  logic [SW-1:0]  low_idx;
  logic [SW-1:0]  next_idx;
  logic           any_valid;
  logic           step_edge;

  // Split the flat source bus into bytes. Padding slots beyond NUM_SRC read as
  // zero and are never valid, so sel can never settle on them.
  generate
    for (genvar gi = 0; gi < VW; gi++) begin : g_bytes
      if (gi < NUM_SRC) begin : g_real
        assign src_bytes[gi] = src_data[gi*8 +: 8];
      end else begin : g_pad
        assign src_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign valid_ext = VW'(src_valid);
  assign any_valid = |src_valid;
  assign step_edge = step & ~step_q_reg;

  // Lowest valid index, used when leaving IDLE.
  always_comb begin
    logic [SW-1:0] cand;
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = SW'(i);
      if (valid_ext[cand]) low_idx = cand;
    end
  end

  // First valid index after sel_reg, wrapping modulo NUM_SRC. The last
  // candidate examined is sel_reg itself, so a lone valid source keeps its slot.
  always_comb begin
    logic [SW-1:0] cand;
    next_idx = sel_reg;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = SW'((int'(sel_reg) + k) % NUM_SRC);
      if (valid_ext[cand]) next_idx = cand;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    data_out_next = data_out_reg;
    blank_next    = blank_reg;
    switched_next = 1'b0;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        blank_next    = 1'b1;
        data_out_next = 8'h00;
        cnt_next      = '0;
        if (any_valid) begin
          sel_next      = low_idx;
          switched_next = 1'b1;
          state_next    = SHOW;
        end
      end
      SHOW: begin
        blank_next    = 1'b0;
        data_out_next = src_bytes[sel_reg];
        if (!any_valid) begin
          // Blank on the same edge that IDLE is entered.
          blank_next    = 1'b1;
          data_out_next = 8'h00;
          cnt_next      = '0;
          state_next    = IDLE;
        end else if (!valid_ext[sel_reg] || step_edge ||
                     (cnt_reg == DWELL_LAST && !hold)) begin
          state_next = ADVANCE;
        end else if (!hold) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ADVANCE: begin
        cnt_next = '0;
        if (!any_valid) begin
          blank_next    = 1'b1;
          data_out_next = 8'h00;
          state_next    = IDLE;
        end else begin
          sel_next      = next_idx;
          switched_next = (next_idx != sel_reg);
          state_next    = SHOW;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset takes effect without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      data_out_reg <= 8'h00;
      blank_reg    <= 1'b1;
      switched_reg <= 1'b0;
      cnt_reg      <= '0;
      step_q_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      data_out_reg <= data_out_next;
      blank_reg    <= blank_next;
      switched_reg <= switched_next;
      cnt_reg      <= cnt_next;
      step_q_reg   <= step;
    end
  end

  assign data_out = data_out_reg;
  assign sel      = sel_reg;
  assign blank    = blank_reg;
  assign switched = switched_reg;

endmodule

// File: tb/tb_disp_source_sched.sv
// tb_disp_source_sched: directed vector table for power-up and round-robin,
// followed by hand-written sequences for hold, step, invalidation, a single
// source and asynchronous reset. NUM_SRC=4, DWELL=4 (5 cycles per source).
module tb_disp_source_sched;

  logic        clk;
  logic        rst_n;
  logic [31:0] src_data;
  logic [3:0]  src_valid;
  logic        hold;
  logic        step;
  logic [7:0]  data_out;
  logic [1:0]  sel;
  logic        blank;
  logic        switched;

  int errors = 0;
  int checks = 0;

  disp_source_sched #(.NUM_SRC(4), .DWELL(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_data (src_data),
    .src_valid(src_valid),
    .hold     (hold),
    .step     (step),
    .data_out (data_out),
    .sel      (sel),
    .blank    (blank),
    .switched (switched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  sel;
    logic [7:0]  dout;
    logic        blank;
    logic        sw;
  } vec_t;

  localparam logic [31:0] D1 = 32'h44553C11;
  localparam logic [31:0] D2 = 32'h44992211;

  vec_t vecs [26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ticks until switched is seen; n=0 when the bound runs out.
  task automatic wait_switch(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (switched) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sw_cnt;
    int n;

    vecs[0]  = '{4'b0000, D1, 2'd0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{4'b0110, D1, 2'd1, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{4'b0110, D1, 2'd1, 8'h3C, 1'b0, 1'b0};
    vecs[3]  = '{4'b0110, D1, 2'd1, 8'h3C, 1'b0, 1'b0};
    vecs[4]  = '{4'b0110, D1, 2'd1, 8'h3C, 1'b0, 1'b0};
    vecs[5]  = '{4'b0110, D1, 2'd1, 8'h3C, 1'b0, 1'b0};
    vecs[6]  = '{4'b0110, D1, 2'd2, 8'h3C, 1'b0, 1'b1};
    vecs[7]  = '{4'b0110, D1, 2'd2, 8'h55, 1'b0, 1'b0};
    vecs[8]  = '{4'b1011, D2, 2'd2, 8'h99, 1'b0, 1'b0};
    vecs[9]  = '{4'b1011, D2, 2'd3, 8'h99, 1'b0, 1'b1};
    vecs[10] = '{4'b1011, D2, 2'd3, 8'h44, 1'b0, 1'b0};
    vecs[11] = '{4'b1011, D2, 2'd3, 8'h44, 1'b0, 1'b0};
    vecs[12] = '{4'b1011, D2, 2'd3, 8'h44, 1'b0, 1'b0};
    vecs[13] = '{4'b1011, D2, 2'd3, 8'h44, 1'b0, 1'b0};
    vecs[14] = '{4'b1011, D2, 2'd0, 8'h44, 1'b0, 1'b1};
    vecs[15] = '{4'b1011, D2, 2'd0, 8'h11, 1'b0, 1'b0};
    vecs[16] = '{4'b1011, D2, 2'd0, 8'h11, 1'b0, 1'b0};
    vecs[17] = '{4'b1011, D2, 2'd0, 8'h11, 1'b0, 1'b0};
    vecs[18] = '{4'b1011, D2, 2'd0, 8'h11, 1'b0, 1'b0};
    vecs[19] = '{4'b1011, D2, 2'd1, 8'h11, 1'b0, 1'b1};
    vecs[20] = '{4'b1011, D2, 2'd1, 8'h22, 1'b0, 1'b0};
    vecs[21] = '{4'b1011, D2, 2'd1, 8'h22, 1'b0, 1'b0};
    vecs[22] = '{4'b1011, D2, 2'd1, 8'h22, 1'b0, 1'b0};
    vecs[23] = '{4'b1011, D2, 2'd1, 8'h22, 1'b0, 1'b0};
    vecs[24] = '{4'b1011, D2, 2'd3, 8'h22, 1'b0, 1'b1};
    vecs[25] = '{4'b1011, D2, 2'd3, 8'h44, 1'b0, 1'b0};

    rst_n = 1'b1; src_data = D1; src_valid = 4'b0000; hold = 1'b0; step = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset blank", blank, 1);
    check("reset data", data_out, 0);
    check("reset sel", sel, 0);
    check("reset switched", switched, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Power-up, invalidation of src2 and auto round-robin with wrap.
    for (int i = 0; i < 26; i++) begin
      src_valid = vecs[i].valid;
      src_data  = vecs[i].data;
      tick();
      $display("vec %0d valid=%b sel=%0d data=%02h blank=%0b sw=%0b",
               i, src_valid, sel, data_out, blank, switched);
      check($sformatf("v%0d sel", i), sel, vecs[i].sel);
      check($sformatf("v%0d data", i), data_out, vecs[i].dout);
      check($sformatf("v%0d blank", i), blank, vecs[i].blank);
      check($sformatf("v%0d switched", i), switched, vecs[i].sw);
    end

    // Hold mid-dwell on src3: no advance for 20 cycles, data stays live.
    hold = 1'b1;
    sw_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (switched) sw_cnt++;
      check($sformatf("hold sel c%0d", i), sel, 3);
    end
    check("hold switched count", sw_cnt, 0);
    src_data = 32'h5A992211;
    tick();
    check("hold live data", data_out, 8'h5A);
    $display("hold done sel=%0d data=%02h", sel, data_out);

    // One-cycle step pulse while held: exactly one advance (3 -> 0).
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step N sel", sel, 3);
    tick();
    check("step N+1 sel", sel, 0);
    check("step N+1 switched", switched, 1);
    tick();
    check("step N+2 data", data_out, 8'h11);
    sw_cnt = 0;
    repeat (5) begin
      tick();
      if (switched) sw_cnt++;
    end
    check("step pulse extra switches", sw_cnt, 0);
    check("step pulse sel", sel, 0);
    $display("step pulse done sel=%0d data=%02h", sel, data_out);

    // Step held high for 10 cycles: still only one advance (0 -> 1).
    step = 1'b1;
    sw_cnt = 0;
    repeat (10) begin
      tick();
      if (switched) sw_cnt++;
    end
    step = 1'b0;
    check("step level switches", sw_cnt, 1);
    check("step level sel", sel, 1);
    $display("step level done sel=%0d sw_count=%0d", sel, sw_cnt);

    // Count two cycles, freeze three, then resume from the frozen value.
    hold = 1'b0;
    tick();
    tick();
    hold = 1'b1;
    repeat (3) tick();
    check("resume frozen sel", sel, 1);
    hold = 1'b0;
    wait_switch(n);
    check("resume cycles to switch", n, 3);
    check("resume sel", sel, 3);
    $display("resume done sel=%0d after %0d cycles", sel, n);

    // Single valid source: moves to src2 once, then never switches.
    src_valid = 4'b0100;
    tick();
    check("single drop sel", sel, 3);
    tick();
    check("single sel", sel, 2);
    check("single switched", switched, 1);
    hold = 1'b1;
    for (int v = 0; v < 4; v++) begin
      src_data[23:16] = 8'(8'hA0 + v);
      tick();
      check($sformatf("single live v%0d", v), data_out, 8'(8'hA0 + v));
    end
    hold = 1'b0;
    sw_cnt = 0;
    repeat (12) begin
      tick();
      if (switched) sw_cnt++;
    end
    check("single switch count", sw_cnt, 0);
    check("single sel stays", sel, 2);
    $display("single done sel=%0d sw_count=%0d", sel, sw_cnt);

    // Drop src2 while it is shown (under hold): advance to src3 anyway.
    hold = 1'b1;
    repeat (2) tick();
    src_valid = 4'b1010;
    tick();
    check("inval detect sel", sel, 2);
    tick();
    check("inval sel", sel, 3);
    check("inval switched", switched, 1);

    // Drop every valid bit: back to IDLE and blanked, sel unchanged.
    src_valid = 4'b0000;
    tick();
    tick();
    check("idle blank", blank, 1);
    check("idle data", data_out, 0);
    check("idle sel", sel, 3);
    $display("idle done blank=%0b sel=%0d", blank, sel);

    // Restart from IDLE, then reset asynchronously between clock edges.
    hold = 1'b0;
    src_data = D2;
    src_valid = 4'b1011;
    tick();
    check("restart sel", sel, 0);
    check("restart switched", switched, 1);
    wait_switch(n);
    check("restart dwell cycles", n, 5);
    check("restart next sel", sel, 1);
    tick();
    check("pre-reset data", data_out, 8'h22);
    check("pre-reset blank", blank, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset data", data_out, 0);
    check("async reset blank", blank, 1);
    check("async reset sel", sel, 0);
    check("async reset switched", switched, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post-reset sel", sel, 0);
    check("post-reset switched", switched, 1);
    tick();
    check("post-reset data", data_out, 8'h11);
    check("post-reset blank", blank, 0);
    $display("reset done sel=%0d data=%02h", sel, data_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_source_sched.md
# disp_source_sched

Time-shares the two-digit hex display path between several 8-bit sources, such as the instruction pointer, accumulator and status bytes. It selects one valid source at a time, holds it for a programmable dwell period, and then advances round-robin to the next valid source. Its registered `data_out` byte feeds the existing two-digit hex display module directly. It supports a hold control and a manual single-step control for debugging on the board.

## Interface
- `NUM_SRC`, default 4: number of 8-bit sources; legal range 2..16.
- `DWELL`, default 50_000_000: number of clock cycles each source is shown in auto mode; must be ≥ 2.
- `clk` input, 1 bit: system clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `src_data` input, NUM_SRC*8 bits: source i occupies bits [8i+7:8i].
- `src_valid` input, NUM_SRC bits: bit i high means source i may be displayed.
- `hold` input, 1 bit: level; while high, the dwell counter freezes and auto-advance is blocked.
- `step` input, 1 bit: level from a debounced button; each rising edge requests one manual advance.
- `data_out` output, 8 bits: byte to display, registered.
- `sel` output, $clog2(NUM_SRC) bits: index of the source currently shown.
- `blank` output, 1 bit: high when no source is valid; downstream forces the display off.
- `switched` output, 1 bit: one-cycle pulse in the cycle `sel` takes a new value.

## Operation
- State machine has three states: IDLE, SHOW, ADVANCE.
- IDLE:
  - Outputs: `blank`=1, `data_out`=0, dwell counter held at 0.
  - If any `src_valid` bit is high: `sel` ← lowest valid index, `switched` pulses, go to SHOW.
- SHOW:
  - `blank`=0.
  - Every cycle, `data_out` ← `src_data[sel]`, so the display shows live data.
  - Dwell counter increments when `hold`=0.
- SHOW leaves under these conditions, in priority order:
  1. All `src_valid` bits are 0 → IDLE.
  2. `src_valid[sel]`=0 → ADVANCE. Takes effect regardless of `hold`.
  3. A step edge is detected → ADVANCE. Takes effect regardless of `hold`.
  4. Counter = DWELL-1 and `hold`=0 → ADVANCE.
- ADVANCE (one cycle):
  - `sel` ← first valid index after `sel`, searching upward with wrap-around.
  - If the current index is the only valid one, `sel` stays unchanged and `switched` does not pulse. Otherwise `switched` pulses.
  - Counter ← 0, then go to SHOW.
  - If no source is valid in this cycle, go to IDLE with `sel` unchanged.
- Step edge detection:
  - A registered copy of `step` is kept; edge = `step` & ~step_q.
  - A step edge arriving in IDLE or ADVANCE is discarded, not queued.
- Dwell counter:
  - Width is $clog2(DWELL). It never exceeds DWELL-1.
  - It is cleared on every entry to SHOW.
- Hold:
  - Releasing `hold` resumes counting from the frozen value.
  - `data_out` keeps tracking live data while `hold` is high.
- The `sel` search uses an index modulo NUM_SRC. When NUM_SRC is not a power of two, `sel` never takes values ≥ NUM_SRC.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state IDLE, `sel`=0, `data_out`=0, `blank`=1, `switched`=0, counter 0, step_q 0.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.
- After reset release, the first valid source is shown as follows:
  - `sel` is set at edge 1 after a valid bit is seen.
  - `data_out` and `blank`=0 appear at edge 2.
- `data_out` lags `src_data[sel]` by exactly one cycle.
- Auto mode: each source is shown for DWELL cycles in SHOW plus one ADVANCE cycle. The period per source is DWELL+1 cycles.
- During the ADVANCE cycle, `data_out` holds its previous value.
- Step:
  - A rising edge sampled at edge N causes ADVANCE at N+1.
  - The new `sel` appears at N+1 and the new `data_out` at N+2.
- Invalidation of the current source is detected in the same cycle it occurs, with ADVANCE on the next edge.
- If step and dwell expiry happen in the same cycle, only one advance occurs.

## Test plan
- **Reset and power-up:** NUM_SRC=4, DWELL=4, all `src_valid`=0 → `blank`=1, `data_out`=0. Then set `src_valid`=4'b0110 with src1=0x3C → `sel`=1 after 1 edge, `data_out`=0x3C and `blank`=0 after 2 edges.
- **Auto round-robin with wrap:** `src_valid`=4'b1011 with data 0x11/0x22/—/0x44 → `sel` sequence 0,1,3,0,… with 5 cycles per source, and `switched` pulses exactly at each change.
- **Hold and step:** assert `hold` mid-dwell → `sel` stays fixed for 20 cycles. Pulse `step` for one cycle while held → exactly one advance. Hold `step` high for 10 cycles → still only one advance.
- **Invalidation:** while showing src2, drop `src_valid[2]` → ADVANCE on the next edge to the next valid source. Drop all valid bits → IDLE with `blank`=1.
- **Single valid source:** `src_valid`=4'b0100 → `sel` stays 2 indefinitely, no `switched` pulses, and `data_out` tracks live changes to src2 with 1-cycle lag.
- **Reset mid-dwell:** assert `rst_n`=0 asynchronously between clock edges → all outputs go to reset values immediately. After release, the sequence restarts from the lowest valid index.
